// File: rtl/wb_commit_unit_if.sv
// rtl/wb_commit_unit_if.sv - MEM/WB bundle input and register-file write-port bus
interface wb_commit_unit_if #(
  parameter int LANES    = 2,
  parameter int D_WIDTH  = 32,
  parameter int RA_WIDTH = 4,
  parameter int WPORTS   = 1
);
  logic [LANES-1:0]          i_valid;
  logic [LANES-1:0]          i_RegWrite;
  logic [LANES-1:0]          i_MemtoReg;
  logic [LANES-1:0]          i_PCSrc;
  logic [LANES*D_WIDTH-1:0]  i_ReadData;
  logic [LANES*D_WIDTH-1:0]  i_ALUOut;
  logic [LANES*RA_WIDTH-1:0] i_WA;
  logic                      i_flush;
  logic                      o_ready;
  logic [WPORTS-1:0]         o_we;
  logic [WPORTS*RA_WIDTH-1:0] o_wa;
  logic [WPORTS*D_WIDTH-1:0] o_wd;
  logic                      o_PCSrc;
  logic                      o_busy;

  modport master (
    output i_valid, i_RegWrite, i_MemtoReg, i_PCSrc, i_ReadData, i_ALUOut, i_WA, i_flush,
    input  o_ready, o_we, o_wa, o_wd, o_PCSrc, o_busy
  );

  modport slave (
    input  i_valid, i_RegWrite, i_MemtoReg, i_PCSrc, i_ReadData, i_ALUOut, i_WA, i_flush,
    output o_ready, o_we, o_wa, o_wd, o_PCSrc, o_busy
  );
endinterface

// File: rtl/wb_commit_unit.sv
// rtl/wb_commit_unit.sv - N-wide write-back/commit stage with squash and multi-cycle drain
module wb_commit_unit #(
  parameter int LANES    = 2,
  parameter int D_WIDTH  = 32,
  parameter int RA_WIDTH = 4,
  parameter int WPORTS   = 1
) (
  input logic            clk,
  input logic            rst_n,
  wb_commit_unit_if.slave bus
);
  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                r_state;
  logic [LANES-1:0]      r_live;
  logic                  r_pc;
  logic [D_WIDTH-1:0]    r_res [LANES];
  logic [RA_WIDTH-1:0]   r_wa  [LANES];

  logic [LANES-1:0]      w_pre;
  logic [LANES-1:0]      w_live;
  logic                  w_branch;
  logic [D_WIDTH-1:0]    w_res [LANES];
  logic [RA_WIDTH-1:0]   w_in_wa [LANES];
  logic [LANES-1:0]      w_retire;
  logic [WPORTS-1:0]     w_we;
  logic [WPORTS*RA_WIDTH-1:0] w_wa;
  logic [WPORTS*D_WIDTH-1:0]  w_wd;
  int                    w_pending;
  logic                  w_ready;
  logic                  w_accept;

  // Per-lane result mux and live mask: lanes after the oldest redirect die, then older WAW losers die
  always_comb begin
    w_pre    = '0;
    w_live   = '0;
    w_branch = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      w_res[k]   = bus.i_MemtoReg[k] ? bus.i_ReadData[k*D_WIDTH +: D_WIDTH]
                                     : bus.i_ALUOut[k*D_WIDTH +: D_WIDTH];
      w_in_wa[k] = bus.i_WA[k*RA_WIDTH +: RA_WIDTH];
      w_pre[k]   = bus.i_valid[k] & bus.i_RegWrite[k] & ~w_branch;
      if (bus.i_valid[k] & bus.i_PCSrc[k]) w_branch = 1'b1;
    end
    for (int k = 0; k < LANES; k++) begin
      w_live[k] = w_pre[k];
      for (int m = k + 1; m < LANES; m++) begin
        if (w_pre[m] && (w_in_wa[m] == w_in_wa[k])) w_live[k] = 1'b0;
      end
    end
  end

  // Map the oldest pending writes onto ports 0..WPORTS-1 in lane order and count what is left
  always_comb begin
    w_we      = '0;
    w_wa      = '0;
    w_wd      = '0;
    w_retire  = '0;
    w_pending = 0;
    for (int k = 0; k < LANES; k++) begin
      if (r_live[k]) begin
        for (int p = 0; p < WPORTS; p++) begin
          if (w_pending == p) begin
            w_we[p]                      = 1'b1;
            w_wa[p*RA_WIDTH +: RA_WIDTH] = r_wa[k];
            w_wd[p*D_WIDTH +: D_WIDTH]   = r_res[k];
            w_retire[k]                  = 1'b1;
          end
        end
        w_pending = w_pending + 1;
      end
    end
  end

  // Ready when the buffer will be empty after this edge, so the next bundle loads without a bubble
  assign w_ready  = (r_state == IDLE) || (w_pending <= WPORTS);
  assign w_accept = (|bus.i_valid) & w_ready & ~bus.i_flush;

  // Holding-buffer FSM: load on accept, retire presented writes each DRAIN cycle, flush empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_live  <= '0;
      r_pc    <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r_res[k] <= '0;
        r_wa[k]  <= '0;
      end
    end else if (bus.i_flush) begin
      r_state <= IDLE;
      r_live  <= '0;
      r_pc    <= 1'b0;
    end else if (w_accept) begin
      r_live  <= w_live;
      r_pc    <= w_branch;
      r_state <= ((|w_live) || w_branch) ? DRAIN : IDLE;
      for (int k = 0; k < LANES; k++) begin
        r_res[k] <= w_res[k];
        r_wa[k]  <= w_in_wa[k];
      end
    end else begin
      r_live  <= r_live & ~w_retire;
      r_pc    <= 1'b0;
      r_state <= (|(r_live & ~w_retire)) ? DRAIN : IDLE;
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_we    = w_we;
  assign bus.o_wa    = w_wa;
  assign bus.o_wd    = w_wd;
  assign bus.o_PCSrc = r_pc;
  assign bus.o_busy  = (r_state == DRAIN);
endmodule
